top_entity: RTL and testbench

Runtime-verification monitor for a three-input, three-output specification built around two sliding-window aggregates. Input events and periodic timer ticks are merged into event records and buffered in a small event queue. An evaluator pops one record per cycle, updates the window buckets and drives the outputs with activity flags. The block is the top of the monitor and sits between the input capture logic and the verdict and trace consumers.

---
 rtl/top_entity.sv | 239 +++++++++++++++++++++++
 tb/tb_top_entity.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top_entity.sv
// ---------------------------------------------------------------------------
// top_entity : runtime-verification monitor built around two sliding windows.
//
// Input events and the periodic timer tick are merged into event records and
// buffered in a small FIFO. The evaluator pops one record per cycle. It
// updates the window buckets and drives the output streams with activity
// flags.
//
// Parameters
//   PERIOD_CYCLES : clock cycles per periodic tick
//   W0_BUCKETS    : period buckets in window 0 (sum of input_0)
//   W1_BUCKETS    : period buckets in window 1 (count of input_1 events)
//   Q_DEPTH       : event queue depth (>= 2)
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   en                       : enable; low holds all state and forces the
//                              flag and q_* outputs to 0
//   input_i / new_input_i    : input value and its presence strobe (i = 0..2)
//   output_i                 : output stream values (held between evaluations)
//   output_i_aktv            : output i was evaluated this cycle
//   q_push / q_push_valid    : record offered / accepted by the queue
//   q_pop  / q_pop_valid     : evaluator request / record delivered
//   pacing_i                 : output i scheduled in the evaluated record
//   slide_0 / slide_1        : window 0 / 1 rotated in the evaluated record
// ---------------------------------------------------------------------------
module top_entity #(
   parameter int unsigned PERIOD_CYCLES = 500,
   parameter int unsigned W0_BUCKETS    = 2,
   parameter int unsigned W1_BUCKETS    = 3,
   parameter int unsigned Q_DEPTH       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [63:0] input_0,
   input  logic signed [63:0] input_1,
   input  logic signed [63:0] input_2,
   input  logic               new_input_0,
   input  logic               new_input_1,
   input  logic               new_input_2,
   output logic signed [63:0] output_0,
   output logic signed [63:0] output_1,
   output logic signed [63:0] output_2,
   output logic               output_0_aktv,
   output logic               output_1_aktv,
   output logic               output_2_aktv,
   output logic               q_push,
   output logic               q_pop,
   output logic               q_push_valid,
   output logic               q_pop_valid,
   output logic               pacing_0,
   output logic               pacing_1,
   output logic               pacing_2,
   output logic               slide_0,
   output logic               slide_1
);

   localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int unsigned PW = $clog2(Q_DEPTH);
   localparam int unsigned NW = $clog2(Q_DEPTH + 1);

   // input_1 only contributes its presence: window 1 counts events.
   typedef struct packed {
      logic [63:0] v0;
      logic [63:0] v2;
      logic        n0;
      logic        n1;
      logic        n2;
      logic        tick;
   } rec_t;

   // Reset gates the combinational queue strobes so that every q_* output
   // reads 0 while reset is held.
   logic act;
   assign act = en & ~rst;

   // ---------------- timebase ----------------
   logic [CW-1:0] tb_cnt;
   logic          tick;

   assign tick = act && (tb_cnt == CW'(PERIOD_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_cnt <= '0;
      end else if (en) begin
         tb_cnt <= tick ? '0 : tb_cnt + 1'b1;
      end
   end

   // ---------------- event queue ----------------
   rec_t          mem [Q_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count;
   logic          full, empty, push, push_ok, pop_ok;
   rec_t          in_rec, head;

   assign full    = (count == NW'(Q_DEPTH));
   assign empty   = (count == '0);
   assign push    = act & (new_input_0 | new_input_1 | new_input_2 | tick);
   assign pop_ok  = act & ~empty;
   // A simultaneous pop frees a slot, so a full queue still accepts.
   assign push_ok = push & (~full | pop_ok);

   assign q_push       = push;
   assign q_pop        = act;
   assign q_push_valid = push_ok;
   assign q_pop_valid  = pop_ok;

   always_comb begin
      in_rec      = '0;
      in_rec.v0   = input_0;
      in_rec.v2   = input_2;
      in_rec.n0   = new_input_0;
      in_rec.n1   = new_input_1;
      in_rec.n2   = new_input_2;
      in_rec.tick = tick;
   end

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= in_rec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == PW'(Q_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == PW'(Q_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- evaluator ----------------
   // Bucket [0] is the current period; higher indices are older periods.
   logic [63:0] w0 [W0_BUCKETS];
   logic [63:0] w1 [W1_BUCKETS];
   logic [63:0] w0_nxt [W0_BUCKETS];
   logic [63:0] w1_nxt [W1_BUCKETS];
   logic [63:0] w0_cur, w1_cur, sum0, sum1, o0_latest, o2_val;
   logic [63:0] o0_q, o1_q, o2_q;
   logic        o0_seen;
   logic [2:0]  aktv_q;
   logic [1:0]  slide_q;

   always_comb begin
      w0_cur = w0[0] + (head.n0 ? head.v0 : 64'd0);
      w1_cur = w1[0] + (head.n1 ? 64'd1 : 64'd0);

      sum0 = w0_cur;
      for (int unsigned i = 1; i < W0_BUCKETS; i++) begin
         sum0 = sum0 + w0[i];
      end
      sum1 = w1_cur;
      for (int unsigned i = 1; i < W1_BUCKETS; i++) begin
         sum1 = sum1 + w1[i];
      end

      // A tick in the same record supplies a fresh output_0 to output_2.
      o0_latest = head.tick ? sum0 : (o0_seen ? o0_q : 64'd0);
      o2_val    = head.v2 + o0_latest;

      // Rotation walks from the oldest bucket down so each slot picks up
      // its neighbour's value before that neighbour is overwritten.
      w0_nxt    = w0;
      w0_nxt[0] = w0_cur;
      w1_nxt    = w1;
      w1_nxt[0] = w1_cur;
      if (head.tick) begin
         for (int unsigned i = W0_BUCKETS - 1; i >= 1; i--) begin
            w0_nxt[i] = w0_nxt[i-1];
         end
         w0_nxt[0] = '0;
         for (int unsigned i = W1_BUCKETS - 1; i >= 1; i--) begin
            w1_nxt[i] = w1_nxt[i-1];
         end
         w1_nxt[0] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < W0_BUCKETS; i++) w0[i] <= '0;
         for (int unsigned i = 0; i < W1_BUCKETS; i++) w1[i] <= '0;
         o0_q    <= '0;
         o1_q    <= '0;
         o2_q    <= '0;
         o0_seen <= 1'b0;
         aktv_q  <= '0;
         slide_q <= '0;
      end else if (en) begin
         aktv_q  <= '0;
         slide_q <= '0;
         if (pop_ok) begin
            w0      <= w0_nxt;
            w1      <= w1_nxt;
            aktv_q  <= {head.n2, head.tick, head.tick};
            slide_q <= {2{head.tick}};
            if (head.tick) begin
               o0_q    <= sum0;
               o1_q    <= sum1;
               o0_seen <= 1'b1;
            end
            if (head.n2) begin
               o2_q <= o2_val;
            end
         end
      end
   end

   assign output_0 = o0_q;
   assign output_1 = o1_q;
   assign output_2 = o2_q;

   assign output_0_aktv = act & aktv_q[0];
   assign output_1_aktv = act & aktv_q[1];
   assign output_2_aktv = act & aktv_q[2];
   assign pacing_0      = act & aktv_q[0];
   assign pacing_1      = act & aktv_q[1];
   assign pacing_2      = act & aktv_q[2];
   assign slide_0       = act & slide_q[0];
   assign slide_1       = act & slide_q[1];

endmodule

// File: tb/tb_top_entity.sv
// ---------------------------------------------------------------------------
// tb_top_entity : self-checking bench for top_entity.
// A reference model predicts each evaluated record when its stimulus is
// driven and queues the prediction; predictions are popped and compared in
// the cycle the evaluation becomes visible on the outputs.
// ---------------------------------------------------------------------------
module tb_top_entity;

   localparam int P = 500;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en  = 1'b0;
   logic signed [63:0] input_0 = '0, input_1 = '0, input_2 = '0;
   logic               new_input_0 = 1'b0, new_input_1 = 1'b0, new_input_2 = 1'b0;
   logic signed [63:0] output_0, output_1, output_2;
   logic               output_0_aktv, output_1_aktv, output_2_aktv;
   logic               q_push, q_pop, q_push_valid, q_pop_valid;
   logic               pacing_0, pacing_1, pacing_2, slide_0, slide_1;

   top_entity #(
      .PERIOD_CYCLES(P),
      .W0_BUCKETS   (2),
      .W1_BUCKETS   (3),
      .Q_DEPTH      (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .input_0      (input_0),
      .input_1      (input_1),
      .input_2      (input_2),
      .new_input_0  (new_input_0),
      .new_input_1  (new_input_1),
      .new_input_2  (new_input_2),
      .output_0     (output_0),
      .output_1     (output_1),
      .output_2     (output_2),
      .output_0_aktv(output_0_aktv),
      .output_1_aktv(output_1_aktv),
      .output_2_aktv(output_2_aktv),
      .q_push       (q_push),
      .q_pop        (q_pop),
      .q_push_valid (q_push_valid),
      .q_pop_valid  (q_pop_valid),
      .pacing_0     (pacing_0),
      .pacing_1     (pacing_1),
      .pacing_2     (pacing_2),
      .slide_0      (slide_0),
      .slide_1      (slide_1)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [7:0]  flags;
      logic [63:0] o0;
      logic [63:0] o1;
      logic [63:0] o2;
   } exp_t;

   exp_t        sb [$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          tb_cnt   = 0;
   bit          prev_push = 1'b0;
   logic [63:0] m0 [2];
   logic [63:0] m1 [3];
   logic [63:0] mo0, mo1, mo2;
   bit          mseen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] dut_flags();
      return {output_0_aktv, output_1_aktv, output_2_aktv,
              pacing_0, pacing_1, pacing_2, slide_0, slide_1};
   endfunction

   task automatic model_reset();
      m0 = '{default: '0};
      m1 = '{default: '0};
      mo0 = '0; mo1 = '0; mo2 = '0;
      mseen = 1'b0;
      tb_cnt = 0;
      prev_push = 1'b0;
   endtask

   // Compare whatever the DUT shows at this sampling point.
   task automatic monitor();
      exp_t x;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         x = sb.pop_front();
         check("sb_late", 64'(cyc), 64'(x.due));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         x = sb.pop_front();
         check("flags", 64'(dut_flags()), 64'(x.flags));
         check("output_0", output_0, x.o0);
         check("output_1", output_1, x.o1);
         check("output_2", output_2, x.o2);
      end else begin
         check("idle_flags", 64'(dut_flags()), 64'd0);
      end
   endtask

   // One clock cycle of stimulus; called and returning at a falling edge.
   task automatic step(input bit e, input bit n0, input logic [63:0] v0,
                       input bit n1, input bit n2, input logic [63:0] v2);
      bit   tk, push;
      exp_t x;
      monitor();
      en = e;
      new_input_0 = n0; input_0 = v0;
      new_input_1 = n1; input_1 = {$urandom, $urandom};
      new_input_2 = n2; input_2 = v2;
      tk   = e && (tb_cnt == P - 1);
      push = e && (n0 || n1 || n2 || tk);
      if (push) begin
         if (n0) m0[0] = m0[0] + v0;
         if (n1) m1[0] = m1[0] + 64'd1;
         if (tk) begin
            mo0 = m0[0] + m0[1];
            mo1 = m1[0] + m1[1] + m1[2];
            mseen = 1'b1;
         end
         if (n2) mo2 = v2 + (mseen ? mo0 : 64'd0);
         if (tk) begin
            m0[1] = m0[0]; m0[0] = '0;
            m1[2] = m1[1]; m1[1] = m1[0]; m1[0] = '0;
         end
         x.due   = cyc + 2;
         x.flags = {tk, tk, n2, tk, tk, n2, tk, tk};
         x.o0 = mo0; x.o1 = mo1; x.o2 = mo2;
         sb.push_back(x);
      end
      #1;
      check("q_push", 64'(q_push), 64'(push));
      check("q_push_valid", 64'(q_push_valid), 64'(push));
      check("q_pop", 64'(q_pop), 64'(e));
      check("q_pop_valid", 64'(q_pop_valid), 64'(e && prev_push));
      prev_push = push;
      @(posedge clk);
      cyc++;
      if (e) tb_cnt = tk ? 0 : tb_cnt + 1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0, '0);
   endtask

   // Run to the next tick; the tick record optionally carries a new_input_2.
   task automatic to_tick(input bit n2, input logic [63:0] v2);
      while (tb_cnt != P - 1) step(1, 0, '0, 0, 0, '0);
      step(1, 0, '0, 0, n2, v2);
      idle(2);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out0"}, output_0, 64'd0);
      check({tag, "_out1"}, output_1, 64'd0);
      check({tag, "_out2"}, output_2, 64'd0);
      check({tag, "_flags"}, 64'(dut_flags()), 64'd0);
      check({tag, "_q"}, 64'({q_push, q_pop, q_push_valid, q_pop_valid}), 64'd0);
   endtask

   initial begin
      model_reset();
      en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // two idle periods: ticks report zero sums
      idle(2 * P);
      check("idle_out0", output_0, 64'd0);
      check("idle_out1", output_1, 64'd0);

      // window contents: 1+2+3 on input_0, four input_1 events
      step(1, 1, 64'd1, 1, 0, '0);
      idle(5);
      step(1, 1, 64'd2, 1, 0, '0);
      step(1, 1, 64'd3, 0, 0, '0);
      step(1, 0, '0, 1, 0, '0);
      idle(3);
      step(1, 0, '0, 1, 0, '0);
      to_tick(0, '0);
      check("tickA_out0", output_0, 64'd6);
      check("tickA_out1", output_1, 64'd4);

      // output_2 from held output_0, including wraparound
      step(1, 0, '0, 0, 1, 64'd5);
      idle(2);
      check("out2_plain", output_2, 64'd11);
      step(1, 0, '0, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF);
      idle(2);
      check("out2_wrap", output_2, 64'h8000_0000_0000_0005);

      // enable low: events ignored, timebase held
      for (int i = 0; i < 20; i++) step(0, 1, 64'd100, 1, 1, 64'd9);
      idle(3);

      // tick merged with new_input_2
      to_tick(1, 64'd10);
      check("tickB_out0", output_0, 64'd6);
      check("tickB_out1", output_1, 64'd4);
      check("tickB_out2", output_2, 64'd16);

      step(1, 0, '0, 1, 0, '0);
      to_tick(0, '0);
      check("tickC_out0", output_0, 64'd0);
      check("tickC_out1", output_1, 64'd5);
      to_tick(0, '0);
      check("tickD_out1", output_1, 64'd1);

      // mid-operation reset
      step(1, 1, 64'd7, 1, 1, 64'd3);
      idle(3);
      check("sb_empty_pre_rst", 64'(sb.size()), 64'd0);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(posedge clk); cyc++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      to_tick(0, '0);
      check("post_rst_out0", output_0, 64'd0);
      check("post_rst_out1", output_1, 64'd0);

      idle(3);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
